status_stack: RTL and testbench

- LIFO save/restore unit for the 6-bit processor status word; the reading side of the status register.
- On call/interrupt entry the control unit pushes the current status; on return it pops.
- The popped value is presented on restore_status with a one-cycle restore_valid pulse, which the decoder forwards as dec_status with wr_en asserted.
- Also reports depth, full/empty, and sticky overflow/underflow errors.

---
 rtl/status_stack.sv | 114 +++++++++++
 tb/tb_status_stack.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/status_stack.sv
// rtl/status_stack.sv - LIFO save/restore stack for the processor status word
//
// Ports:
//   clk            system clock, all state updates on rising edge
//   res            synchronous reset, active-high, highest priority
//   status_in      current status word, sampled on push
//   push           save status_in on top of stack
//   pop            remove top entry and present it on restore_status
//   err_clr        clear sticky error flags (a same-cycle error event wins)
//   restore_status registered popped value, held until the next accepted pop
//   restore_valid  one-cycle pulse per accepted pop
//   top_status     registered copy of the current top entry, 0 when empty
//   depth          number of valid entries, 0..Depth
//   empty, full    decoded from the registered depth
//   overflow_err   sticky: push refused because the stack was full
//   underflow_err  sticky: pop refused because the stack was empty

module status_stack #(
    parameter int NumStatusBits = 6,
    parameter int Depth         = 4,
    parameter int DepthBits     = 3
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [NumStatusBits-1:0] status_in,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     err_clr,
    output logic [NumStatusBits-1:0] restore_status,
    output logic                     restore_valid,
    output logic [NumStatusBits-1:0] top_status,
    output logic [DepthBits-1:0]     depth,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    localparam int IdxBits = DepthBits - 1;

    logic [NumStatusBits-1:0] mem [Depth];

    // Depth is a power of two, so the low bits of depth address the next free
    // slot; subtracting in the narrow index width wraps correctly when full.
    logic [IdxBits-1:0] wr_idx;
    logic [IdxBits-1:0] top_idx;
    logic [IdxBits-1:0] below_idx;

    assign wr_idx    = depth[IdxBits-1:0];
    assign top_idx   = wr_idx - IdxBits'(1);
    assign below_idx = wr_idx - IdxBits'(2);

    assign empty = (depth == '0);
    assign full  = (depth == DepthBits'(Depth));

    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
            depth          <= '0;
            restore_status <= '0;
            restore_valid  <= 1'b0;
            top_status     <= '0;
            overflow_err   <= 1'b0;
            underflow_err  <= 1'b0;
        end else begin
            restore_valid <= 1'b0;

            // Clear first so an error event later in this block overrides it.
            if (err_clr) begin
                overflow_err  <= 1'b0;
                underflow_err <= 1'b0;
            end

            case ({push, pop})
                2'b10: begin
                    if (full) begin
                        overflow_err <= 1'b1;
                    end else begin
                        mem[wr_idx] <= status_in;
                        depth       <= depth + DepthBits'(1);
                        top_status  <= status_in;
                    end
                end
                2'b01: begin
                    if (empty) begin
                        underflow_err <= 1'b1;
                    end else begin
                        restore_status <= mem[top_idx];
                        restore_valid  <= 1'b1;
                        depth          <= depth - DepthBits'(1);
                        top_status     <= (depth == DepthBits'(1)) ? '0 : mem[below_idx];
                    end
                end
                2'b11: begin
                    restore_valid <= 1'b1;
                    if (empty) begin
                        // Nothing stored: hand the incoming word straight back.
                        restore_status <= status_in;
                    end else begin
                        // Swap the top entry; depth is unchanged, so no overflow.
                        restore_status <= mem[top_idx];
                        mem[top_idx]   <= status_in;
                        top_status     <= status_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_status_stack.sv
// tb/tb_status_stack.sv - directed vector bench for status_stack

module tb_status_stack;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic [5:0] status_in = '0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       err_clr = 1'b0;
    logic [5:0] restore_status;
    logic       restore_valid;
    logic [5:0] top_status;
    logic [2:0] depth;
    logic       empty;
    logic       full;
    logic       overflow_err;
    logic       underflow_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    status_stack #(
        .NumStatusBits(6),
        .Depth        (4),
        .DepthBits    (3)
    ) dut (
        .clk           (clk),
        .res           (res),
        .status_in     (status_in),
        .push          (push),
        .pop           (pop),
        .err_clr       (err_clr),
        .restore_status(restore_status),
        .restore_valid (restore_valid),
        .top_status    (top_status),
        .depth         (depth),
        .empty         (empty),
        .full          (full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    typedef struct {
        logic       res;
        logic       push;
        logic       pop;
        logic       clr;
        logic [5:0] sin;
        logic [5:0] rs;
        logic       rv;
        logic [2:0] d;
        logic [5:0] top;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic pu, input logic po, input logic c,
                                input logic [5:0] s, input logic [5:0] rs, input logic rv,
                                input logic [2:0] d, input logic [5:0] top,
                                input logic ovf, input logic unf);
        vec_t v;
        v.res = r; v.push = pu; v.pop = po; v.clr = c; v.sin = s;
        v.rs = rs; v.rv = rv; v.d = d; v.top = top; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic step(input logic r, input logic pu, input logic po, input logic c,
                        input logic [5:0] s);
        res = r; push = pu; pop = po; err_clr = c; status_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] rs, input logic rv,
                         input logic [2:0] d, input logic [5:0] top,
                         input logic ovf, input logic unf);
        logic [22:0] got;
        logic [22:0] exp;
        got = {restore_status, restore_valid, depth, top_status, overflow_err, underflow_err,
               empty, full};
        exp = {rs, rv, d, top, ovf, unf, (d == 3'd0), (d == 3'd4)};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got rs=%h rv=%b d=%0d top=%h ovf=%b unf=%b empty=%b full=%b, want rs=%h rv=%b d=%0d top=%h ovf=%b unf=%b empty=%b full=%b",
                     name, restore_status, restore_valid, depth, top_status, overflow_err,
                     underflow_err, empty, full, rs, rv, d, top, ovf, unf, (d == 3'd0),
                     (d == 3'd4));
        end
    endtask

    initial begin
        // res push pop clr sin | rs rv d top ovf unf
        vecs.push_back(mk(1, 1, 1, 0, 6'h3F, 6'h00, 0, 0, 6'h00, 0, 0)); // reset with push+pop
        vecs.push_back(mk(1, 1, 1, 0, 6'h3F, 6'h00, 0, 0, 6'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 6'h2A, 6'h00, 0, 1, 6'h2A, 0, 0)); // LIFO fill
        vecs.push_back(mk(0, 1, 0, 0, 6'h15, 6'h00, 0, 2, 6'h15, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 6'h3F, 6'h00, 0, 3, 6'h3F, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 6'h00, 6'h3F, 1, 2, 6'h15, 0, 0)); // back-to-back pops
        vecs.push_back(mk(0, 0, 1, 0, 6'h00, 6'h15, 1, 1, 6'h2A, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 6'h00, 6'h2A, 1, 0, 6'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 6'h01, 6'h2A, 0, 1, 6'h01, 0, 0)); // fill to full
        vecs.push_back(mk(0, 1, 0, 0, 6'h02, 6'h2A, 0, 2, 6'h02, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 6'h03, 6'h2A, 0, 3, 6'h03, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 6'h04, 6'h2A, 0, 4, 6'h04, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 6'h05, 6'h2A, 0, 4, 6'h04, 1, 0)); // overflow
        vecs.push_back(mk(0, 0, 1, 0, 6'h00, 6'h04, 1, 3, 6'h03, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 6'h00, 6'h03, 1, 2, 6'h02, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 6'h00, 6'h02, 1, 1, 6'h01, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 6'h00, 6'h01, 1, 0, 6'h00, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 6'h00, 6'h01, 0, 0, 6'h00, 1, 1)); // underflow, rs held
        vecs.push_back(mk(0, 0, 0, 1, 6'h00, 6'h01, 0, 0, 6'h00, 0, 0)); // clear
        vecs.push_back(mk(0, 0, 1, 1, 6'h00, 6'h01, 0, 0, 6'h00, 0, 1)); // set beats clear
        vecs.push_back(mk(0, 0, 0, 1, 6'h00, 6'h01, 0, 0, 6'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 6'h10, 6'h01, 0, 1, 6'h10, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 6'h11, 6'h01, 0, 2, 6'h11, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 6'h22, 6'h11, 1, 2, 6'h22, 0, 0)); // swap at depth 2
        vecs.push_back(mk(0, 0, 1, 0, 6'h00, 6'h22, 1, 1, 6'h10, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 6'h00, 6'h10, 1, 0, 6'h00, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 6'h33, 6'h33, 1, 0, 6'h00, 0, 0)); // empty bypass
        vecs.push_back(mk(0, 1, 0, 0, 6'h0A, 6'h33, 0, 1, 6'h0A, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 6'h0B, 6'h33, 0, 2, 6'h0B, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 6'h0C, 6'h33, 0, 3, 6'h0C, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 6'h0D, 6'h33, 0, 4, 6'h0D, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 6'h0E, 6'h0D, 1, 4, 6'h0E, 0, 0)); // swap when full
        vecs.push_back(mk(0, 0, 0, 0, 6'h00, 6'h0D, 0, 4, 6'h0E, 0, 0)); // idle holds
        vecs.push_back(mk(0, 0, 1, 0, 6'h00, 6'h0E, 1, 3, 6'h0C, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].res, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].sin);
            check($sformatf("vec%0d", i), vecs[i].rs, vecs[i].rv, vecs[i].d, vecs[i].top,
                  vecs[i].ovf, vecs[i].unf);
        end

        // Mid-operation reset: the pop issued with res is discarded.
        step(1, 0, 0, 0, 6'h00);
        step(0, 1, 0, 0, 6'h21);
        step(0, 1, 0, 0, 6'h22);
        step(0, 1, 0, 0, 6'h23);
        check("mid_fill", 6'h00, 0, 3, 6'h23, 0, 0);
        step(1, 0, 1, 0, 6'h00);
        check("mid_reset", 6'h00, 0, 0, 6'h00, 0, 0);
        step(0, 0, 1, 0, 6'h00);
        check("post_reset_pop", 6'h00, 0, 0, 6'h00, 0, 1);
        step(0, 0, 0, 0, 6'h00);
        check("post_reset_idle", 6'h00, 0, 0, 6'h00, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
